// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-back, write-allocate data cache with 8 lines of 4 words.
// Ports: clk/rst_n (async active-low); proc_* is the processor side, which holds a request
// stable while proc_stall is high; mem_* is the slow-memory side, with block-wide transfers
// and a one-cycle mem_ready completion pulse.
module dcache_dm (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
  state_t state;
  logic [7:0] valid, dirty;
  logic [24:0] tags [8];
  logic [127:0] data [8];
  logic req, hit;
  logic [2:0] idx;
  logic [6:0] sel;
  assign req = proc_read | proc_write;
  assign idx = proc_addr[4:2];
  assign sel = {proc_addr[1:0], 5'd0};
  // Hit only counts in IDLE; valid gating keeps the unreset tag array from leaking X.
  assign hit = req & (state == IDLE) & valid[idx] & (tags[idx] == proc_addr[29:5]);
  assign proc_rdata = hit ? data[idx][sel +: 32] : 32'd0;
  assign proc_stall = (state != IDLE) | (req & ~hit);
  assign mem_addr = (state == WRITEBACK) ? {tags[idx], idx} : proc_addr[29:2];
  assign mem_wdata = mem_write ? data[idx] : 128'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req & ~hit) begin
            if (valid[idx] & dirty[idx]) begin
              state <= WRITEBACK;
              mem_write <= 1'b1;
            end else begin
              state <= ALLOCATE;
              mem_read <= 1'b1;
            end
          end else if (hit & proc_write) begin
            dirty[idx] <= 1'b1;
          end
        end
        WRITEBACK: if (mem_ready) begin
          state <= ALLOCATE;
          mem_write <= 1'b0;
          mem_read <= 1'b1;
        end
        ALLOCATE: if (mem_ready) begin
          state <= IDLE;
          mem_read <= 1'b0;
          valid[idx] <= 1'b1;
          dirty[idx] <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Arrays carry no reset; reset forces IDLE with valid cleared, so neither write condition can fire.
  always_ff @(posedge clk) begin
    if (state == ALLOCATE && mem_ready) begin
      data[idx] <= mem_rdata;
      tags[idx] <= proc_addr[29:5];
    end else if (hit & proc_write) begin
      data[idx][sel +: 32] <= proc_wdata;
    end
  end
endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: randomized and directed self-checking bench for dcache_dm with a 5-cycle memory model.
module tb_dcache_dm;
  logic clk = 0, rst_n = 0;
  logic proc_read = 0, proc_write = 0;
  logic [29:0] proc_addr = '0;
  logic [31:0] proc_wdata = '0, proc_rdata;
  logic proc_stall, mem_read, mem_write, mem_ready = 0;
  logic [27:0] mem_addr;
  logic [127:0] mem_wdata, mem_rdata = '0;
  int total = 0, bad = 0, cnt = 0;
  int overlap = 0, traffic = 0;
  logic [27:0] last_rd = '0, last_wr = '0;
  logic [127:0] last_wd = '0;
  logic [127:0] bmem [logic [27:0]];
  logic [31:0] ref_w [logic [29:0]];
  bit mv [8];
  bit md [8];
  logic [24:0] mt [8];

  dcache_dm dut (
    .clk(clk), .rst_n(rst_n), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
    .proc_stall(proc_stall), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] blk(input logic [27:0] a);
    logic [127:0] b;
    if (bmem.exists(a)) return bmem[a];
    for (int w = 0; w < 4; w++) b[w*32 +: 32] = {2'b00, a, 2'(w)} ^ 32'h5A5A_0000;
    return b;
  endfunction

  function automatic logic [31:0] exp_w(input logic [29:0] a);
    logic [127:0] b;
    if (ref_w.exists(a)) return ref_w[a];
    b = blk(a[29:2]);
    return b[{a[1:0], 5'd0} +: 32];
  endfunction

  // Slow memory: mem_ready pulses once the request has been seen for 5 edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready <= 0;
      cnt <= 0;
    end else if (mem_ready) begin
      mem_ready <= 0;
      cnt <= 0;
    end else if (mem_read || mem_write) begin
      if (cnt == 4) begin
        mem_ready <= 1;
        cnt <= 0;
        if (mem_write) bmem[mem_addr] = mem_wdata;
        else mem_rdata <= blk(mem_addr);
      end else cnt <= cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) overlap++;
    if (mem_read || mem_write) traffic++;
    if (mem_read) last_rd = mem_addr;
    if (mem_write) begin
      last_wr = mem_addr;
      last_wd = mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd,
                        output int n, output logic [31:0] r);
    @(negedge clk);
    proc_read = rd;
    proc_write = wr;
    proc_addr = a;
    proc_wdata = wd;
    n = 0;
    #1;
    while (proc_stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    r = proc_rdata;
  endtask

  task automatic do_op(input string nm, input logic rd, input logic wr, input logic [29:0] a,
                       input logic [31:0] wd);
    int n, es;
    logic [31:0] r, ev;
    logic [2:0] i;
    bit h;
    i = a[4:2];
    h = mv[i] && mt[i] == a[29:5];
    es = h ? 0 : (mv[i] && md[i]) ? 13 : 7;
    ev = exp_w(a);
    access(rd, wr, a, wd, n, r);
    chk({nm, "_stall"}, n, es);
    if (wr) ref_w[a] = wd;
    else chk({nm, "_rdata"}, r, ev);
    md[i] = (h && md[i]) || wr;
    mv[i] = 1;
    mt[i] = a[29:5];
  endtask

  task automatic idle();
    @(negedge clk);
    proc_read = 0;
    proc_write = 0;
  endtask

  initial begin
    int t, n;
    logic [31:0] r;
    logic [29:0] a;
    logic rd, wr;
    #3;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_stall", proc_stall, 0);
    chk("rst_rdata_known", $isunknown(proc_rdata), 0);
    @(negedge clk);
    rst_n = 1;
    do_op("cold_read4", 1, 0, 30'h4, 0);
    chk("cold_read_addr", last_rd, 32'h1);
    t = traffic;
    do_op("hit_read5", 1, 0, 30'h5, 0);
    chk("hit_no_traffic", traffic - t, 0);
    do_op("wmiss8", 0, 1, 30'h8, 32'hDEADBEEF);
    do_op("whit9", 0, 1, 30'h9, 32'h1234_5678);
    do_op("rhit9", 1, 0, 30'h9, 0);
    do_op("dirty_read28", 1, 0, 30'h28, 0);
    chk("wb_addr", last_wr, 32'h2);
    chk("wb_word0", last_wd[31:0], 32'hDEADBEEF);
    chk("wb_word1", last_wd[63:32], 32'h1234_5678);
    chk("alloc_addr", last_rd, 32'hA);
    idle();
    proc_read = 1;
    proc_addr = 30'h44;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_mem_read", mem_read, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_mem_read", mem_read, 0);
    chk("mid_rst_mem_write", mem_write, 0);
    proc_read = 0;
    #1;
    chk("mid_rst_stall", proc_stall, 0);
    @(negedge clk);
    rst_n = 1;
    ref_w.delete();
    for (int k = 0; k < 8; k++) begin
      mv[k] = 0;
      md[k] = 0;
    end
    do_op("rerun_read44", 1, 0, 30'h44, 0);
    do_op("post_rst_read4", 1, 0, 30'h4, 0);
    for (int k = 0; k < 64; k++) begin
      a = {25'($urandom_range(0, 1) + 2 * ((k / 8) % 2)), 3'(k % 8), 2'($urandom_range(0, 3))};
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      do_op("sweep", rd, wr, a, $urandom);
    end
    for (int k = 0; k < 32; k++) begin
      a = {25'(k % 4), 3'(k / 4), 2'(k)};
      do_op("final_read", 1, 0, a, 0);
    end
    idle();
    #1;
    chk("idle_stall", proc_stall, 0);
    chk("no_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
